// File: rtl/drum_synth_pkg.sv
// Shared constants and helpers for the five-voice drum tone generator.
package drum_synth_pkg;

  localparam int VOICES     = 5;
  localparam int VOICE_A    = 0;
  localparam int VOICE_B    = 1;
  localparam int VOICE_C    = 2;
  localparam int VOICE_D    = 3;
  localparam int VOICE_E    = 4;

  localparam int DEF_BURST_LEN = 2500000;
  localparam int DEF_HALF_A    = 100000;
  localparam int DEF_HALF_B    = 50000;
  localparam int DEF_HALF_C    = 25000;
  localparam int DEF_HALF_D    = 12500;
  localparam int DEF_HALF_E    = 6250;
  localparam int DEF_DIV_W     = 17;

  localparam int PWM_PERIOD    = 5;

  // Number of voices whose gated square level is high; five voices fit in 3 bits.
  function automatic logic [2:0] popcount_voices(input logic [VOICES-1:0] v);
    logic [2:0] sum;
    sum = 3'd0;
    for (int i = 0; i < VOICES; i++) begin
      sum = sum + {2'b00, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/drum_voice.sv
// One drum voice: a fixed-length burst timer gating a square-wave tone divider.
module drum_voice
  import drum_synth_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int HALF      = DEF_HALF_A,
  parameter int DIV_W     = DEF_DIV_W
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic trig,
  input  logic mute,
  output logic active,
  output logic square
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             active_r;
  logic             square_r;

  // Burst timer and tone divider; mute beats trigger, trigger restarts a running burst.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r    <= CNT_ZERO;
      div_r    <= DIV_ZERO;
      active_r <= 1'b0;
      square_r <= 1'b0;
    end else if (mute) begin
      cnt_r    <= CNT_ZERO;
      div_r    <= DIV_ZERO;
      active_r <= 1'b0;
      square_r <= 1'b0;
    end else if (trig) begin
      cnt_r    <= CNT_LOAD;
      div_r    <= DIV_ZERO;
      active_r <= 1'b1;
      square_r <= 1'b1;
    end else if (active_r) begin
      if (cnt_r == CNT_ZERO) begin
        // Last cycle of the burst: drop to idle so no tone lingers.
        active_r <= 1'b0;
        square_r <= 1'b0;
        div_r    <= DIV_ZERO;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
        if (div_r == DIV_LAST) begin
          div_r    <= DIV_ZERO;
          square_r <= ~square_r;
        end else begin
          div_r <= div_r + DIV_ONE;
        end
      end
    end else begin
      div_r    <= DIV_ZERO;
      square_r <= 1'b0;
    end
  end

  assign active = active_r;
  assign square = square_r;

endmodule

// File: rtl/drum_voice_synth.sv
// Five-voice drum tone burst generator with a 3-bit mix level and 5-phase PWM output.
module drum_voice_synth
  import drum_synth_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int HALF_A    = DEF_HALF_A,
  parameter int HALF_B    = DEF_HALF_B,
  parameter int HALF_C    = DEF_HALF_C,
  parameter int HALF_D    = DEF_HALF_D,
  parameter int HALF_E    = DEF_HALF_E,
  parameter int DIV_W     = DEF_DIV_W
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       CCEN,
  input  logic       Playing,
  input  logic [4:0] Hit,
  output logic [4:0] Active,
  output logic [2:0] Audio,
  output logic       Pwm
);

  localparam logic [2:0] PWM_LAST = 3'(PWM_PERIOD - 1);

  logic              strobe_d_r;
  logic [VOICES-1:0] trig_s;
  logic              mute_s;
  logic [VOICES-1:0] active_s;
  logic [VOICES-1:0] square_s;
  logic [2:0]        audio_r;
  logic [2:0]        pwm_cnt_r;
  logic              pwm_r;

  // Hit is valid one cycle after the step strobe, so triggers use the delayed strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      strobe_d_r <= 1'b0;
    end else begin
      strobe_d_r <= CCEN;
    end
  end

  assign trig_s = {VOICES{strobe_d_r & Playing}} & Hit;
  assign mute_s = ~Playing;

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    localparam int H = (i == VOICE_A) ? HALF_A :
                       (i == VOICE_B) ? HALF_B :
                       (i == VOICE_C) ? HALF_C :
                       (i == VOICE_D) ? HALF_D : HALF_E;
    drum_voice #(
      .BURST_LEN (BURST_LEN),
      .HALF      (H),
      .DIV_W     (DIV_W)
    ) u_voice (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .trig    (trig_s[i]),
      .mute    (mute_s),
      .active  (active_s[i]),
      .square  (square_s[i])
    );
  end

  // Mix level: count of voices currently sounding a high square level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      audio_r <= 3'd0;
    end else begin
      audio_r <= popcount_voices(active_s & square_s);
    end
  end

  // Free-running PWM phase and comparator; level 0 is always low, level 5 always high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pwm_cnt_r <= 3'd0;
      pwm_r     <= 1'b0;
    end else begin
      if (pwm_cnt_r == PWM_LAST) begin
        pwm_cnt_r <= 3'd0;
      end else begin
        pwm_cnt_r <= pwm_cnt_r + 3'd1;
      end
      pwm_r <= (pwm_cnt_r < audio_r);
    end
  end

  assign Active = active_s;
  assign Audio  = audio_r;
  assign Pwm    = pwm_r;

endmodule
